impl_window_checker: RTL

//  Synthesisable N-channel implication monitor: per channel checks ante |-> ##[MIN_DLY:MAX_DLY] cons.

---
 rtl/impl_chk_pkg.sv | 21 ++
 rtl/impl_window_checker_lane.sv | 82 ++++++++
 rtl/impl_window_checker.sv | 82 ++++++++
 3 files changed

// File: rtl/impl_chk_pkg.sv
// Shared limits and saturating-add helper for the implication window checker.
package impl_chk_pkg;

    localparam int unsigned MAX_DLY_LIMIT = 15;
    localparam int unsigned MAX_CH        = 32;

    // Adds inc to cnt and clamps to the largest w-bit value instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                            input logic [31:0] inc,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max;
        max = (33'd1 << w) - 33'd1;
        sum = {1'b0, cnt} + {1'b0, inc};
        if (sum > max) begin
            return max[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/impl_window_checker_lane.sv
// One channel of the implication checker: pending-attempt shift vector,
// pass/fail resolution, saturating counters and sticky fail bit.
module impl_chk_lane
    import impl_chk_pkg::*;
#(
    parameter int unsigned MIN_DLY = 0,
    parameter int unsigned MAX_DLY = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_ante,
    input  logic             i_cons,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_fail_sticky,
    output logic             o_fail
);

    localparam int unsigned PW = (MAX_DLY == 0) ? 1 : MAX_DLY;
    localparam int unsigned IW = $clog2(MAX_DLY_LIMIT + 2);

    // r_pend[j] holds an attempt started j+1 cycles ago that is still unresolved.
    logic [PW-1:0]    r_pend;
    logic [PW-1:0]    w_pend_d;
    logic [MAX_DLY:0] w_live;
    logic [MAX_DLY:0] w_sat;
    logic [IW-1:0]    w_pass_inc;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_fail_sticky;

    always_comb begin
        w_live     = '0;
        w_sat      = '0;
        w_pend_d   = '0;
        w_pass_inc = '0;
        if (i_en) begin
            w_live[0] = i_ante;
            for (int unsigned k = 1; k <= MAX_DLY; k++) begin
                w_live[k] = r_pend[k-1];
            end
        end
        for (int unsigned k = 0; k <= MAX_DLY; k++) begin
            w_sat[k]   = w_live[k] & i_cons & (k >= MIN_DLY);
            w_pass_inc = w_pass_inc + IW'(w_sat[k]);
        end
        for (int unsigned k = 0; k < MAX_DLY; k++) begin
            w_pend_d[k] = w_live[k] & ~w_sat[k];
        end
    end

    assign o_fail = w_live[MAX_DLY] & ~i_cons;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pend        <= '0;
            r_pass_cnt    <= '0;
            r_fail_cnt    <= '0;
            r_fail_sticky <= 1'b0;
        end else begin
            r_pend <= w_pend_d;
            // Clear drops this cycle's results but leaves pending attempts alive.
            if (i_clear) begin
                r_pass_cnt    <= '0;
                r_fail_cnt    <= '0;
                r_fail_sticky <= 1'b0;
            end else begin
                r_pass_cnt    <= CNT_W'(sat_add(32'(r_pass_cnt), 32'(w_pass_inc), CNT_W));
                r_fail_cnt    <= CNT_W'(sat_add(32'(r_fail_cnt), 32'(o_fail), CNT_W));
                r_fail_sticky <= r_fail_sticky | o_fail;
            end
        end
    end

    assign o_pass_cnt    = r_pass_cnt;
    assign o_fail_cnt    = r_fail_cnt;
    assign o_fail_sticky = r_fail_sticky;

endmodule

// File: rtl/impl_window_checker.sv
// N-channel on-chip monitor for ante |-> ##[MIN_DLY:MAX_DLY] cons with
// counters, sticky flags, first-fail capture and a fail interrupt.
module impl_window_checker
    import impl_chk_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned MIN_DLY = 0,
    parameter int unsigned MAX_DLY = 2,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_CH-1:0]       i_en,
    input  logic [N_CH-1:0]       i_ante,
    input  logic [N_CH-1:0]       i_cons,
    input  logic                  i_clear,
    output logic [N_CH*CNT_W-1:0] o_pass_cnt,
    output logic [N_CH*CNT_W-1:0] o_fail_cnt,
    output logic [N_CH-1:0]       o_fail_sticky,
    output logic                  o_first_fail_vld,
    output logic [CH_W-1:0]       o_first_fail_ch,
    output logic                  o_irq
);

    logic [N_CH-1:0] w_fail;
    logic [CH_W-1:0] w_first_ch;
    logic            r_first_vld;
    logic [CH_W-1:0] r_first_ch;
    logic            r_irq;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        impl_chk_lane #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY),
            .CNT_W   (CNT_W)
        ) u_lane (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_en          (i_en[i]),
            .i_ante        (i_ante[i]),
            .i_cons        (i_cons[i]),
            .i_clear       (i_clear),
            .o_pass_cnt    (o_pass_cnt[i*CNT_W +: CNT_W]),
            .o_fail_cnt    (o_fail_cnt[i*CNT_W +: CNT_W]),
            .o_fail_sticky (o_fail_sticky[i]),
            .o_fail        (w_fail[i])
        );
    end

    // Scan high to low so the lowest failing index wins.
    always_comb begin
        w_first_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_fail[i]) begin
                w_first_ch = CH_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_first_vld <= 1'b0;
            r_first_ch  <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= (|w_fail) & ~i_clear;
            if (i_clear) begin
                r_first_vld <= 1'b0;
                r_first_ch  <= '0;
            end else if (!r_first_vld && (|w_fail)) begin
                r_first_vld <= 1'b1;
                r_first_ch  <= w_first_ch;
            end
        end
    end

    assign o_first_fail_vld = r_first_vld;
    assign o_first_fail_ch  = r_first_ch;
    assign o_irq            = r_irq;

endmodule
